// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester A/B and SRAM-port bundle for sram_arbiter
//
// Purpose: groups the A fetch port, the B load/store port and the SRAM
// read/write port signals so they travel as one bundle.
// Modports:
//   slave  - the arbiter: takes requests and read_data, drives grants,
//            responses and the SRAM read/write port.
//   master - the requesters plus the SRAM: the mirror image of slave.
interface sram_arbiter_if #(
  parameter int LOGDEPTH = 10
);
  // Requester A (read-only)
  logic                a_req;
  logic [LOGDEPTH-1:0] a_addr;
  logic                a_gnt;
  logic                a_rvalid;
  logic [31:0]         a_rdata;
  // Requester B (read/write)
  logic                b_req;
  logic                b_we;
  logic [LOGDEPTH-1:0] b_addr;
  logic [3:0]          b_byte_en;
  logic [31:0]         b_wdata;
  logic                b_gnt;
  logic                b_rvalid;
  logic [31:0]         b_rdata;
  // SRAM ports
  logic                read_req;
  logic [LOGDEPTH-1:0] read_addr;
  logic [31:0]         read_data;
  logic                write_req;
  logic [LOGDEPTH-1:0] write_addr;
  logic [3:0]          write_byte_en;
  logic [31:0]         write_data;

  modport slave (
    input  a_req, a_addr,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_byte_en, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output read_req, read_addr,
    input  read_data,
    output write_req, write_addr, write_byte_en, write_data
  );

  modport master (
    output a_req, a_addr,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_byte_en, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  read_req, read_addr,
    output read_data,
    input  write_req, write_addr, write_byte_en, write_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin read arbiter sharing one SRAM between fetch (A) and load/store (B)
//
// Purpose: B writes go straight to the SRAM write port; A and B reads share
// the single read port with round-robin priority. Read data comes back one
// cycle after the grant, steered by the registered owner. An A read to the
// word being written by B in the same cycle is held off one cycle so A never
// reads the pre-write value.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - sram_arbiter_if.slave: A port, B port, SRAM read/write port
module sram_arbiter #(
  parameter int DEPTH = 1024
) (
  input logic          clk,
  input logic          reset_n,
  sram_arbiter_if.slave bus
);
  localparam int LOGDEPTH = $clog2(DEPTH);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;
  typedef enum logic       {LAST_A, LAST_B} last_t;

  owner_t owner;
  last_t  last_rd;

  logic b_wr;
  logic b_rd;
  logic hazard;
  logic a_rd_ok;
  logic grant_a;
  logic grant_b;

  always_comb begin
    b_wr    = bus.b_req & bus.b_we;
    b_rd    = bus.b_req & ~bus.b_we;
    // The SRAM reads before it writes on the same edge, so a same-word
    // read alongside a write would return the old word.
    hazard  = bus.a_req & b_wr & (bus.a_addr == bus.b_addr);
    a_rd_ok = bus.a_req & ~hazard;
    // On a tie the requester that did not win the last read goes first.
    grant_a = a_rd_ok & (~b_rd | (last_rd == LAST_B));
    grant_b = b_rd & (~a_rd_ok | (last_rd == LAST_A));
  end

  // Grants and port strobes are forced low while reset is asserted.
  assign bus.a_gnt         = reset_n & grant_a;
  assign bus.b_gnt         = reset_n & (b_wr | grant_b);
  assign bus.read_req      = reset_n & (grant_a | grant_b);
  assign bus.read_addr     = grant_b ? bus.b_addr : bus.a_addr;
  assign bus.write_req     = reset_n & b_wr;
  assign bus.write_addr    = bus.b_addr;
  assign bus.write_byte_en = bus.b_byte_en;
  assign bus.write_data    = bus.b_wdata;

  // owner is cleared asynchronously, so a response in flight when reset
  // hits disappears at once and never reappears after release.
  assign bus.a_rvalid = reset_n & (owner == OWN_A);
  assign bus.b_rvalid = reset_n & (owner == OWN_B);
  assign bus.a_rdata  = bus.read_data;
  assign bus.b_rdata  = bus.read_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner   <= OWN_NONE;
      last_rd <= LAST_B;
    end else begin
      if (grant_a) begin
        owner   <= OWN_A;
        last_rd <= LAST_A;
      end else if (grant_b) begin
        owner   <= OWN_B;
        last_rd <= LAST_B;
      end else begin
        owner   <= OWN_NONE;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = (LOGDEPTH > 0);
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares one `sram` instance between the instruction-fetch path (requester A, read-only) and the load/store path (requester B, read/write). It routes B writes to the SRAM write port and arbitrates reads from A and B on the single read port with round-robin priority. It returns each read response to its owner one cycle after the grant. It also stalls an A read that collides with a same-cycle B write to the same word, so A never sees stale data.

## Interface
- `DEPTH`, 1024, SRAM depth in 32-bit words; must match the attached `sram`.
- `LOGDEPTH`, `$clog2(DEPTH)`, word-address width (localparam).

- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `a_req`  in  1  A read request
- `a_addr`  in  LOGDEPTH  A word address
- `a_gnt`  out  1  A request accepted this cycle
- `a_rvalid`  out  1  A read data valid
- `a_rdata`  out  32  A read data
- `b_req`  in  1  B request
- `b_we`  in  1  B request is a write (1) or read (0)
- `b_addr`  in  LOGDEPTH  B word address
- `b_byte_en`  in  4  B write byte enables
- `b_wdata`  in  32  B write data
- `b_gnt`  out  1  B request accepted this cycle
- `b_rvalid`  out  1  B read data valid; never asserted for writes
- `b_rdata`  out  32  B read data
- `read_req`, `read_addr`  out  1, LOGDEPTH  to SRAM read port
- `read_data`  in  32  from SRAM
- `write_req`, `write_addr`, `write_byte_en`, `write_data`  out  1, LOGDEPTH, 4, 32  to SRAM write port

## Operation
- Requests follow a level handshake: a requester holds its req and payload until it sees gnt high in the same cycle. Grants are combinational from the current-cycle requests and state.
- B write (`b_req & b_we`): always granted. Drives `write_req=1` and passes addr, byte_en and data straight through.
- Read contention: if both `a_req` and `b_req & ~b_we` are high, grant the requester that was not granted last. `last_rd` records the winner of the most recent read grant of either kind. A sole read requester is granted regardless of `last_rd`.
- Hazard: if `a_req & b_req & b_we & (a_addr == b_addr)`, A is not granted that cycle. The B write proceeds. `last_rd` is unchanged.
- A read and a B write to different addresses are both granted in the same cycle.
- The read grant drives `read_req=1` and `read_addr` from the winner. It also registers `owner` (NONE/A/B) for the next cycle.
- Response: in the cycle after a grant, `owner` selects the output. `a_rvalid=(owner==A)` and `b_rvalid=(owner==B)`. Both `a_rdata` and `b_rdata` equal `read_data` unconditionally, so they are only meaningful while the matching rvalid is high.
- With no read grant, `read_req=0`. `read_addr` is don't-care and is driven from `a_addr`.
- There is no response backpressure. Requesters must accept rvalid when it arrives.

## Timing
- Read latency: grant in cycle T, data and rvalid in cycle T+1 for exactly one cycle.
- Back-to-back reads are supported, one per cycle. Full throughput is a read plus a write every cycle.
- A write granted in cycle T is visible to any read granted in T+1 or later.
- Reset value of `owner` is NONE. Reset value of `last_rd` is B, so A wins the first read tie.
- While `reset_n=0`, all gnt, rvalid, `read_req` and `write_req` outputs are forced to 0.
- Reset asserted mid-transaction drops any in-flight response. No rvalid is produced after reset is released for a grant made before reset.

## Test plan
- After reset, preload word 5=0xDEADBEEF; A reads addr 5 -> `a_gnt=1` same cycle, `a_rvalid=1` with `a_rdata=0xDEADBEEF` next cycle, `b_rvalid=0`.
- A and B both read every cycle (A addr 1, B addr 2) for 6 cycles -> grants alternate A,B,A,B,A,B, and each rvalid carries the matching word.
- B writes 0x11223344 with byte_en 4'b0101 to addr 9 (old 0xFFFFFFFF), then B reads addr 9 -> `b_rdata=0xFF22FF44`.
- Same cycle: A reads addr 7, B writes 0xCAFEF00D to addr 7 -> `a_gnt=0`, `b_gnt=1`. Next cycle `a_gnt=1`, and the following cycle `a_rdata=0xCAFEF00D`.
- Same cycle: A reads addr 3, B writes addr 4 -> both granted, `read_req` and `write_req` both 1, A data returned next cycle.
- Assert `reset_n=0` asynchronously the cycle after a B read grant -> `b_rvalid` goes 0 immediately and stays 0 after release. The first tie after release goes to A.
